// File: rtl/load_store_unit.sv
// Load/store initiator for a byte-addressed memory that is 64 bits wide.
// Each request is handled alone. Sub-double stores are done as a read-modify-write of the aligned double.
module load_store_unit #(
    parameter int MEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] Mem_Addr,
    output logic [63:0] Write_Data,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [63:0] Read_Data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] buf_q, buf_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Accept-time legality: natural alignment and the whole access inside memory.
    logic [3:0]  req_bytes;
    logic [64:0] req_end;
    logic        req_err;

    always_comb begin
        req_bytes = 4'd1 << req_size;
        req_end   = {1'b0, req_addr} + 65'(req_bytes);
        req_err   = ((req_addr[2:0] & (req_bytes[2:0] - 3'd1)) != 3'd0)
                  || (req_end > 65'(MEM_BYTES));
    end

    // Lane extraction works on the double being read this cycle. That is the value the buffer captures.
    logic [63:0] lane_data;
    logic [63:0] load_ext;

    always_comb begin
        lane_data = Read_Data >> {addr_q[2:0], 3'b000};
        case (size_q)
            2'd0:    load_ext = uns_q ? {56'd0, lane_data[7:0]}  : {{56{lane_data[7]}},  lane_data[7:0]};
            2'd1:    load_ext = uns_q ? {48'd0, lane_data[15:0]} : {{48{lane_data[15]}}, lane_data[15:0]};
            2'd2:    load_ext = uns_q ? {32'd0, lane_data[31:0]} : {{32{lane_data[31]}}, lane_data[31:0]};
            default: load_ext = lane_data;
        endcase
    end

    // Store merge: wdata bytes are placed at the lane. The other bytes come from the buffer.
    // A double store has an all-ones mask, so the result is just wdata.
    logic [7:0]  byte_mask;
    logic [63:0] bit_mask;
    logic [63:0] wdata_sh;
    logic [63:0] merged;

    always_comb begin
        case (size_q)
            2'd0:    byte_mask = 8'h01;
            2'd1:    byte_mask = 8'h03;
            2'd2:    byte_mask = 8'h0F;
            default: byte_mask = 8'hFF;
        endcase
        byte_mask = byte_mask << addr_q[2:0];
        for (int b = 0; b < 8; b++) begin
            bit_mask[8*b +: 8] = {8{byte_mask[b]}};
        end
        wdata_sh = wdata_q << {addr_q[2:0], 3'b000};
        merged   = (buf_q & ~bit_mask) | (wdata_sh & bit_mask);
    end

    always_comb begin
        // NOTE: every *_d gets a hold default first, so no path leaves one unassigned (no latches).
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_err) begin
                        state_d = RESP;
                        rdata_d = 64'd0;
                        err_d   = 1'b1;
                    end else if (!req_we || req_size != 2'd3) begin
                        state_d = READ;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            READ: begin
                buf_d = Read_Data;
                if (we_q) begin
                    state_d = WRITE;
                end else begin
                    state_d = RESP;
                    rdata_d = load_ext;
                    err_d   = 1'b0;
                end
            end
            WRITE: begin
                state_d = RESP;
                rdata_d = 64'd0;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments, so every flop samples the values from before the edge.
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            buf_q   <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
        MemRead    = (state_q == READ);
        // Reset is combinational here so a write in flight never reaches memory.
        MemWrite   = (state_q == WRITE) && !reset;
        Mem_Addr   = (state_q == READ || state_q == WRITE) ? {addr_q[63:3], 3'b000} : 64'd0;
        Write_Data = (state_q == WRITE) ? merged : 64'd0;
    end

endmodule
